// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide engine.
package muldiv_pkg;

    // RISC-V M-extension funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Operand signedness for an op: {rs1 signed, rs2 signed}
    function automatic logic [1:0] op_signs(input logic [2:0] f3);
        logic [1:0] s;
        s = 2'b00;
        case (f3)
            F3_MUL:    s = 2'b00;
            F3_MULH:   s = 2'b11;
            F3_MULHSU: s = 2'b10;
            F3_MULHU:  s = 2'b00;
            F3_DIV:    s = 2'b11;
            F3_DIVU:   s = 2'b00;
            F3_REM:    s = 2'b11;
            F3_REMU:   s = 2'b00;
            default:   s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring compare-subtract-shift divide.
// Multiply: a = product high half, b = multiplier/low half, m = multiplicand.
// Divide:   a = partial remainder, b = dividend/quotient, m = divisor.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            mode_div,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [XLEN-1:0] m_in,
    output logic [XLEN-1:0] a_out_c,
    output logic [XLEN-1:0] b_out_c
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff;

    // Single step in the selected mode
    always_comb begin
        sum     = {1'b0, a_in} + (b_in[0] ? {1'b0, m_in} : (XLEN+1)'(0));
        shifted = {a_in, b_in[XLEN-1]};
        ge      = (shifted >= {1'b0, m_in});
        // Remainder stays below the divisor, so the low XLEN bits of the difference suffice
        diff    = shifted[XLEN-1:0] - m_in;
        if (mode_div) begin
            a_out_c = ge ? diff : shifted[XLEN-1:0];
            b_out_c = {b_in[XLEN-2:0], ge};
        end else begin
            a_out_c = sum[XLEN:1];
            b_out_c = {sum[0], b_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with flush and corner-case fast path.
module rv_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            KILL,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned N_STEPS = XLEN / UNROLL;
    localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic              busy_d, done_d;
    logic [XLEN-1:0]   result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;

    logic [1:0]        signs;
    logic              op1_neg, op2_neg, in_div, in_rem, neg_in;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   abs1, abs2, fast_val;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    logic [XLEN-1:0]   chain_a [UNROLL+1];
    logic [XLEN-1:0]   chain_b [UNROLL+1];

    assign chain_a[0] = a_q;
    assign chain_b[0] = b_q;

    // Unrolled chain of radix-2 steps evaluated each CALC cycle
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .mode_div (f3_q[2]),
            .a_in     (chain_a[i]),
            .b_in     (chain_b[i]),
            .m_in     (m_q),
            .a_out_c  (chain_a[i+1]),
            .b_out_c  (chain_b[i+1])
        );
    end

    // Decode of the incoming request: magnitudes, result sign, fast-path result
    always_comb begin
        signs    = op_signs(FUNCT3);
        in_div   = FUNCT3[2];
        in_rem   = FUNCT3[1];
        op1_neg  = signs[1] & OPERAND1[XLEN-1];
        op2_neg  = signs[0] & OPERAND2[XLEN-1];
        abs1     = op1_neg ? -OPERAND1 : OPERAND1;
        abs2     = op2_neg ? -OPERAND2 : OPERAND2;
        // Signed remainder follows the dividend; everything else is the product of signs
        neg_in   = (in_div && in_rem) ? op1_neg : (op1_neg ^ op2_neg);
        div_zero = in_div && (OPERAND2 == '0);
        div_ovf  = in_div && signs[0] && (OPERAND1 == MIN_NEG) && (OPERAND2 == '1);
        fast_val = '0;
        if (div_zero) begin
            fast_val = in_rem ? OPERAND1 : '1;
        end else if (div_ovf) begin
            fast_val = in_rem ? '0 : OPERAND1;
        end
    end

    // Sign fixup and half selection of the finished accumulator
    always_comb begin
        prod_fix = neg_q ? -{a_q, b_q} : {a_q, b_q};
        quo_fix  = neg_q ? -b_q : b_q;
        rem_fix  = neg_q ? -a_q : a_q;
        if (f3_q[2]) begin
            fix_val = f3_q[1] ? rem_fix : quo_fix;
        end else if (f3_q == F3_MUL) begin
            fix_val = prod_fix[XLEN-1:0];
        end else begin
            fix_val = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        busy_d   = BUSY;
        done_d   = 1'b0;
        result_d = RESULT;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (START && !KILL) begin
                    f3_d  = FUNCT3;
                    neg_d = neg_in;
                    a_d   = '0;
                    b_d   = abs1;
                    m_d   = abs2;
                    cnt_d = CNT_W'(N_STEPS);
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = fast_val;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (KILL) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    a_d   = chain_a[UNROLL];
                    b_d   = chain_b[UNROLL];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIXUP;
                    end
                end
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!KILL) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = fix_val;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RESULT  <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            RESULT  <= result_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit (XLEN=32, UNROLL=1).
module tb_rv_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int NORMAL_LAT = 34;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            START;
    logic [2:0]      FUNCT3;
    logic [XLEN-1:0] OPERAND1;
    logic [XLEN-1:0] OPERAND2;
    logic            KILL;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    rv_muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .FUNCT3   (FUNCT3),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .KILL     (KILL),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        int              at;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [XLEN-1:0] last_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                check("done_without_op", 64'(DONE), 64'(0));
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(RESULT), 64'(e.res));
                check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.at));
            end
        end
    end

    // Issue one op, holding START through the busy period until DONE is seen
    task automatic issue(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input bit fast);
        int  e0;
        int  busy_cnt;
        bit  got;
        exp_t item;
        @(negedge CLK);
        e0       = cyc;
        START    = 1'b1;
        FUNCT3   = f3;
        OPERAND1 = a;
        OPERAND2 = b;
        item.name = name;
        item.res  = res;
        item.at   = e0 + (fast ? 1 : NORMAL_LAT);
        sb.push_back(item);
        busy_cnt = 0;
        got      = 1'b0;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge CLK);
            if (BUSY === 1'b1) busy_cnt++;
            if (DONE === 1'b1) got = 1'b1;
        end
        START = 1'b0;
        if (!got) begin
            check({name, "_timeout"}, 64'(DONE), 64'(1));
            void'(sb.pop_back());
        end
        check({name, "_busy_cycles"}, 64'(busy_cnt), fast ? 64'(0) : 64'(NORMAL_LAT - 1));
        last_res = res;
    endtask

    initial begin : global_timeout
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int e0;
        RESET    = 1'b1;
        START    = 1'b0;
        KILL     = 1'b0;
        FUNCT3   = 3'b000;
        OPERAND1 = '0;
        OPERAND2 = '0;
        last_res = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("reset_busy", 64'(BUSY), 64'(0));
        check("reset_done", 64'(DONE), 64'(0));
        check("reset_result", 64'(RESULT), 64'(0));

        issue("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        issue("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        issue("mulhu",    3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        issue("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
        issue("mulhu_max",3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        issue("mul_m1sq", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        issue("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        issue("divu",     3'b101, 32'd100,       32'd7,         32'd14,        1'b0);
        issue("remu",     3'b111, 32'd100,       32'd7,         32'd2,         1'b0);
        issue("divu_by0", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
        issue("rem_by0",  3'b110, 32'd5,         32'd0,         32'd5,         1'b1);
        issue("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        issue("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        issue("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);

        // Flush mid-divide: no DONE, result untouched, then a fresh op completes
        @(negedge CLK);
        e0       = cyc;
        START    = 1'b1;
        FUNCT3   = 3'b100;
        OPERAND1 = 32'd100;
        OPERAND2 = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        while (cyc < e0 + 10) @(negedge CLK);
        check("kill_busy_before", 64'(BUSY), 64'(1));
        KILL = 1'b1;
        @(negedge CLK);
        KILL = 1'b0;
        check("kill_busy_after", 64'(BUSY), 64'(0));
        check("kill_result_held", 64'(RESULT), 64'(last_res));
        issue("after_kill", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b0);

        // Reset mid-multiply discards the op and clears the result
        @(negedge CLK);
        e0       = cyc;
        START    = 1'b1;
        FUNCT3   = 3'b000;
        OPERAND1 = 32'd3;
        OPERAND2 = 32'd5;
        @(negedge CLK);
        START = 1'b0;
        while (cyc < e0 + 5) @(negedge CLK);
        check("rst_busy_before", 64'(BUSY), 64'(1));
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_mid_busy", 64'(BUSY), 64'(0));
        check("rst_mid_done", 64'(DONE), 64'(0));
        check("rst_mid_result", 64'(RESULT), 64'(0));
        repeat (40) @(negedge CLK);

        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
